// File: rtl/switch_box_config_loader.sv
// Configuration loader for one universal switch box: assembles a word stream into a
// shadow register and commits it atomically to the active configuration vector.
module switch_box_config_loader #(
    parameter int WS = 7,
    parameter int WD = 6,
    parameter int DW = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cfg_valid,
    output logic                        cfg_ready,
    input  logic [DW-1:0]               cfg_data,
    input  logic                        cfg_last,
    output logic [WS*6+(WD/2)*6-1:0]    c,
    output logic                        c_valid,
    output logic                        load_error,
    output logic                        busy
);

    localparam int CW   = WS * 6 + (WD / 2) * 6;
    localparam int NW   = (CW + DW - 1) / DW;
    localparam int CNTW = (NW > 1) ? $clog2(NW) : 1;
    localparam int SW   = NW * DW;
    localparam logic [CNTW-1:0] LAST_IDX = CNTW'(NW - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [SW-1:0]     shadow_q, shadow_d;
    logic [CW-1:0]     c_q, c_d;
    logic              c_valid_q, c_valid_d;
    logic              load_error_q, load_error_d;
    logic              cfg_ready_q, cfg_ready_d;
    logic              busy_q, busy_d;
    logic              accept_s;

    assign accept_s = cfg_valid && cfg_ready_q;

    // Frame sequencing, shadow assembly and commit decision
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shadow_d     = shadow_q;
        c_d          = c_q;
        c_valid_d    = 1'b0;
        load_error_d = load_error_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    shadow_d[DW-1:0] = cfg_data;
                    if (cfg_last) begin
                        if (NW == 1) begin
                            state_d = COMMIT;
                        end else begin
                            load_error_d = 1'b1;
                        end
                    end else if (NW == 1) begin
                        // Single-word frames have no LOAD phase: a missing last is a long frame.
                        load_error_d = 1'b1;
                        state_d      = DRAIN;
                    end else begin
                        state_d = LOAD;
                        cnt_d   = CNTW'(1);
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                if (accept_s) begin
                    shadow_d[int'(cnt_q) * DW +: DW] = cfg_data;
                    if (cfg_last) begin
                        if (cnt_q == LAST_IDX) begin
                            state_d = COMMIT;
                        end else begin
                            load_error_d = 1'b1;
                            state_d      = IDLE;
                        end
                    end else if (cnt_q == LAST_IDX) begin
                        load_error_d = 1'b1;
                        state_d      = DRAIN;
                    end else begin
                        cnt_d = cnt_q + CNTW'(1);
                    end
                end else begin
                    state_d = LOAD;
                end
            end
            COMMIT: begin
                c_d          = shadow_q[CW-1:0];
                c_valid_d    = 1'b1;
                load_error_d = 1'b0;
                state_d      = IDLE;
            end
            DRAIN: begin
                if (accept_s && cfg_last) begin
                    state_d = IDLE;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Handshake and status flags are registered from the next state so they track state_q
        cfg_ready_d = (state_d != COMMIT);
        busy_d      = (state_d != IDLE);
    end

    // State, shadow and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            shadow_q     <= '0;
            c_q          <= '0;
            c_valid_q    <= 1'b0;
            load_error_q <= 1'b0;
            cfg_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shadow_q     <= shadow_d;
            c_q          <= c_d;
            c_valid_q    <= c_valid_d;
            load_error_q <= load_error_d;
            cfg_ready_q  <= cfg_ready_d;
            busy_q       <= busy_d;
        end
    end

    assign cfg_ready  = cfg_ready_q;
    assign c          = c_q;
    assign c_valid    = c_valid_q;
    assign load_error = load_error_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_switch_box_config_loader.sv
// Directed self-checking bench for switch_box_config_loader (WS=7, WD=6, DW=8: 60 config bits, 8 words).
module tb_switch_box_config_loader;

    localparam logic [59:0] EXP_A = 60'hFCDAB8967452301;
    localparam logic [59:0] EXP_B = 60'hEDCBA9876543210;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [7:0]  cfg_data;
    logic        cfg_last;
    logic [59:0] c;
    logic        c_valid;
    logic        load_error;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] frame_a [10];
    logic [7:0] frame_b [10];
    logic [7:0] frame_z [10];

    switch_box_config_loader #(.WS(7), .WD(6), .DW(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_data   (cfg_data),
        .cfg_last   (cfg_last),
        .c          (c),
        .c_valid    (c_valid),
        .load_error (load_error),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) cyc <= cyc + 1;

    // Presents one word and returns #1 after the edge that accepted it (bounded wait).
    task automatic send_word(input logic [7:0] d, input logic l);
        int   n   = 0;
        logic acc = 1'b0;
        cfg_valid = 1'b1;
        cfg_data  = d;
        cfg_last  = l;
        while (!acc && n < 20) begin
            acc = cfg_ready;
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL accept_timeout: word %h not accepted within %0d cycles", d, n);
        end
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
        cfg_data  = 8'h00;
    endtask

    task automatic send_frame(input logic [7:0] w [10], input int n, input int first, input int cnt);
        for (int i = first; i < first + cnt; i++) begin
            send_word(w[i], (i == n - 1) ? 1'b1 : 1'b0);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (c !== 60'h0 || c_valid !== 1'b0 || load_error !== 1'b0 || busy !== 1'b0 || cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: c=%h cv=%b err=%b busy=%b rdy=%b required c=0 cv=0 err=0 busy=0 rdy=1",
                     c, c_valid, load_error, busy, cfg_ready);
        end
    endtask

    task automatic test_good_frame();
        int t0 = cyc;
        send_frame(frame_a, 8, 0, 8);
        checks++;
        if (c_valid !== 1'b0 || busy !== 1'b1 || cfg_ready !== 1'b0 || c !== 60'h0) begin
            errors++;
            $display("FAIL good_commit_phase: cv=%b busy=%b rdy=%b c=%h required cv=0 busy=1 rdy=0 c=0",
                     c_valid, busy, cfg_ready, c);
        end
        @(posedge clk);
        #1;
        checks++;
        if (c !== EXP_A || c_valid !== 1'b1 || load_error !== 1'b0 || busy !== 1'b0 || cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL good_commit: c=%h cv=%b err=%b busy=%b rdy=%b required c=%h cv=1 err=0 busy=0 rdy=1",
                     c, c_valid, load_error, busy, cfg_ready, EXP_A);
        end
        checks++;
        if (cyc - t0 !== 9) begin
            errors++;
            $display("FAIL good_latency: got %0d cycles required 9", cyc - t0);
        end
        @(posedge clk);
        #1;
        checks++;
        if (c_valid !== 1'b0 || c !== EXP_A) begin
            errors++;
            $display("FAIL good_pulse_once: cv=%b c=%h required cv=0 c=%h", c_valid, c, EXP_A);
        end
    endtask

    task automatic test_stall();
        int t0;
        do_reset();
        t0 = cyc;
        send_frame(frame_a, 8, 0, 4);
        for (int i = 0; i < 3; i++) begin
            cfg_valid = 1'b0;
            cfg_data  = 8'hFF;
            cfg_last  = 1'b1;
            @(posedge clk);
            #1;
            checks++;
            if (busy !== 1'b1 || load_error !== 1'b0 || c !== 60'h0) begin
                errors++;
                $display("FAIL stall_hold: busy=%b err=%b c=%h required busy=1 err=0 c=0", busy, load_error, c);
            end
        end
        cfg_last = 1'b0;
        send_frame(frame_a, 8, 4, 4);
        @(posedge clk);
        #1;
        checks++;
        if (c !== EXP_A || c_valid !== 1'b1 || cyc - t0 !== 12) begin
            errors++;
            $display("FAIL stall_commit: c=%h cv=%b cycles=%0d required c=%h cv=1 cycles=12",
                     c, c_valid, cyc - t0, EXP_A);
        end
    endtask

    task automatic test_short_frame();
        send_frame(frame_b, 5, 0, 5);
        checks++;
        if (load_error !== 1'b1 || c !== EXP_A || c_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL short_error: err=%b c=%h cv=%b busy=%b required err=1 c=%h cv=0 busy=0",
                     load_error, c, c_valid, busy, EXP_A);
        end
        @(posedge clk);
        #1;
        checks++;
        if (c_valid !== 1'b0 || c !== EXP_A) begin
            errors++;
            $display("FAIL short_no_commit: cv=%b c=%h required cv=0 c=%h", c_valid, c, EXP_A);
        end
        send_frame(frame_b, 8, 0, 1);
        checks++;
        if (load_error !== 1'b1) begin
            errors++;
            $display("FAIL short_sticky: err=%b required 1", load_error);
        end
        send_frame(frame_b, 8, 1, 7);
        @(posedge clk);
        #1;
        checks++;
        if (c !== EXP_B || c_valid !== 1'b1 || load_error !== 1'b0) begin
            errors++;
            $display("FAIL short_recover: c=%h cv=%b err=%b required c=%h cv=1 err=0",
                     c, c_valid, load_error, EXP_B);
        end
    endtask

    task automatic test_long_frame();
        send_frame(frame_a, 10, 0, 8);
        checks++;
        if (load_error !== 1'b1 || busy !== 1'b1 || c !== EXP_B || c_valid !== 1'b0) begin
            errors++;
            $display("FAIL long_error_word7: err=%b busy=%b c=%h cv=%b required err=1 busy=1 c=%h cv=0",
                     load_error, busy, c, c_valid, EXP_B);
        end
        send_frame(frame_a, 10, 8, 1);
        checks++;
        if (busy !== 1'b1 || c_valid !== 1'b0) begin
            errors++;
            $display("FAIL long_drain: busy=%b cv=%b required busy=1 cv=0", busy, c_valid);
        end
        send_frame(frame_a, 10, 9, 1);
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || c !== EXP_B || c_valid !== 1'b0 || load_error !== 1'b1) begin
            errors++;
            $display("FAIL long_drain_end: busy=%b c=%h cv=%b err=%b required busy=0 c=%h cv=0 err=1",
                     busy, c, c_valid, load_error, EXP_B);
        end
        send_frame(frame_a, 8, 0, 8);
        @(posedge clk);
        #1;
        checks++;
        if (c !== EXP_A || c_valid !== 1'b1 || load_error !== 1'b0) begin
            errors++;
            $display("FAIL long_recover: c=%h cv=%b err=%b required c=%h cv=1 err=0",
                     c, c_valid, load_error, EXP_A);
        end
    endtask

    task automatic test_reset_mid_frame();
        send_frame(frame_b, 8, 0, 5);
        do_reset();
        checks++;
        if (c !== 60'h0 || busy !== 1'b0 || cfg_ready !== 1'b1 || load_error !== 1'b0 || c_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_state: c=%h busy=%b rdy=%b err=%b cv=%b required c=0 busy=0 rdy=1 err=0 cv=0",
                     c, busy, cfg_ready, load_error, c_valid);
        end
        send_frame(frame_b, 8, 0, 8);
        @(posedge clk);
        #1;
        checks++;
        if (c !== EXP_B || c_valid !== 1'b1) begin
            errors++;
            $display("FAIL midreset_recover: c=%h cv=%b required c=%h cv=1", c, c_valid, EXP_B);
        end
    endtask

    task automatic test_single_word_last();
        send_word(8'h5A, 1'b1);
        checks++;
        if (load_error !== 1'b1 || busy !== 1'b0 || c !== EXP_B) begin
            errors++;
            $display("FAIL idle_last_error: err=%b busy=%b c=%h required err=1 busy=0 c=%h",
                     load_error, busy, c, EXP_B);
        end
    endtask

    task automatic test_switch_bit();
        send_frame(frame_z, 8, 0, 8);
        @(posedge clk);
        #1;
        checks++;
        if (c !== 60'h1 || c[0] !== 1'b1) begin
            errors++;
            $display("FAIL switch_bit0_on: c=%h required 1", c);
        end
        frame_z[0] = 8'h00;
        send_frame(frame_z, 8, 0, 8);
        @(posedge clk);
        #1;
        checks++;
        if (c !== 60'h0 || c_valid !== 1'b1) begin
            errors++;
            $display("FAIL switch_all_open: c=%h cv=%b required c=0 cv=1", c, c_valid);
        end
    endtask

    initial begin
        rst       = 1'b1;
        cfg_valid = 1'b0;
        cfg_data  = 8'h00;
        cfg_last  = 1'b0;
        frame_a = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF, 8'h3C, 8'hC3};
        frame_b = '{8'h10, 8'h32, 8'h54, 8'h76, 8'h98, 8'hBA, 8'hDC, 8'hFE, 8'h00, 8'h00};
        frame_z = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        test_reset();
        test_good_frame();
        test_stall();
        test_short_frame();
        test_long_frame();
        test_reset_mid_frame();
        test_single_word_last();
        test_switch_bit();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
